// File: rtl/clk_period_meter_if.sv
// clk_period_meter_if: control inputs and measurement results of clk_period_meter.
//   enable    - measurement enable (driven by the consumer)
//   sig_in    - asynchronous waveform under measurement
//   period    - clk cycles between the last two rising edges of sig_in
//   high_time - clk cycles from a rising edge to the following falling edge
//   valid     - one-cycle strobe when period/high_time update
//   timeout   - level, no rising edge seen within TIMEOUT cycles
// Modports: master = the meter itself, slave = the consumer of the results.
interface clk_period_meter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             enable;
  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             timeout;

  modport master (
    input  enable, sig_in,
    output period, high_time, valid, timeout
  );

  modport slave (
    output enable, sig_in,
    input  period, high_time, valid, timeout
  );
endinterface

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of an asynchronous input,
// counted in clk cycles. Results are held registers with a one-cycle valid
// strobe; timeout flags a stalled or missing input.
// Ports:
//   clk   - system clock, all state on its rising edge
//   reset - asynchronous, active-high; clears all state
//   bus   - clk_period_meter_if.master (enable, sig_in in; results out)
module clk_period_meter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  clk_period_meter_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  localparam logic [WIDTH-1:0] TMO = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_d;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [WIDTH-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] hi, hi_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  // s1/s2 form the synchronizer; s3 is the delayed copy for edge detection.
  // The synchronizer runs regardless of enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hi        <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      hi        <= hi_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  // Priority: enable = 0 > rise > timeout > fall.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    hi_d      = hi;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (!bus.enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      hi_d    = '0;
    end else begin
      case (state)
        IDLE: begin
          state_d = ARM;
          cnt_d   = '0;
          hi_d    = '0;
        end
        ARM: begin
          // The first rise only starts the measurement; cnt runs here
          // solely so a missing input is flagged.
          if (rise) begin
            cnt_d   = ONE;
            state_d = MEASURE;
          end else if (cnt == TMO) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt + ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_d  = cnt;
            high_d    = hi;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = ONE;
          end else if (cnt == TMO) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            hi_d      = '0;
            state_d   = ARM;
          end else begin
            cnt_d = cnt + ONE;
            if (fall) begin
              hi_d = cnt;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          hi_d    = '0;
        end
      endcase
    end
  end

  assign bus.period    = period_q;
  assign bus.high_time = high_q;
  assign bus.valid     = valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
`timescale 1ns/1ps
module tb_clk_period_meter;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 50;

  logic clk;
  logic reset;

  clk_period_meter_if #(.WIDTH(WIDTH)) bus ();

  clk_period_meter #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned p;
    int unsigned h;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  bit          armed = 0;
  int unsigned prev_p = 0;
  int unsigned prev_h = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Square wave: n periods of p cycles, high for h. Each rise while the
  // meter is measuring reports the period that just ended.
  task automatic wave(input int unsigned p, input int unsigned h, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      if (armed) sb.push_back('{p: prev_p, h: prev_h});
      armed  = 1;
      prev_p = p;
      prev_h = h;
      bus.sig_in = 1'b1;
      repeat (h) @(negedge clk);
      bus.sig_in = 1'b0;
      repeat (p - h) @(negedge clk);
    end
  endtask

  task automatic phase_end(input string name);
    repeat (5) @(negedge clk);
    check({name, "_pending"}, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every strobe pops the next expected result.
  initial begin : monitor
    exp_t e;
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_v = 1'b0;
      end else begin
        if (bus.valid) begin
          check("valid_one_cycle", 64'(prev_v), 64'd0);
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid: got period=%0d high_time=%0d, expected no strobe at %0t",
                     bus.period, bus.high_time, $time);
          end else begin
            e = sb.pop_front();
            check("period", 64'(bus.period), 64'(e.p));
            check("high_time", 64'(bus.high_time), 64'(e.h));
          end
        end
        prev_v = bus.valid;
      end
    end
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset      = 1'b1;
    bus.enable = 1'b0;
    bus.sig_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_period",    64'(bus.period),    64'd0);
    check("reset_high_time", 64'(bus.high_time), 64'd0);
    check("reset_valid",     64'(bus.valid),     64'd0);
    check("reset_timeout",   64'(bus.timeout),   64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Steady wave, then period change, then minimum period, back to back.
    bus.enable = 1'b1;
    armed = 0;
    wave(10, 4, 6);
    wave(20, 8, 4);
    wave(2, 1, 8);
    phase_end("steady_change_min");
    check("no_timeout", 64'(bus.timeout), 64'd0);

    // Enable drop mid-period: results hold, no strobes while disabled.
    bus.enable = 1'b0;
    repeat (3) begin
      bus.sig_in = 1'b1;
      repeat (3) @(negedge clk);
      bus.sig_in = 1'b0;
      repeat (3) @(negedge clk);
    end
    check("disabled_period",    64'(bus.period),    64'd2);
    check("disabled_high_time", 64'(bus.high_time), 64'd1);
    check("disabled_timeout",   64'(bus.timeout),   64'd0);
    repeat (4) @(negedge clk);
    bus.enable = 1'b1;
    armed = 0;
    wave(12, 5, 4);
    phase_end("reenable");

    // Asynchronous reset between clk edges in the middle of a period.
    bus.sig_in = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_period",    64'(bus.period),    64'd0);
    check("async_rst_high_time", 64'(bus.high_time), 64'd0);
    check("async_rst_valid",     64'(bus.valid),     64'd0);
    check("async_rst_timeout",   64'(bus.timeout),   64'd0);
    sb.delete();
    @(negedge clk);
    bus.sig_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    armed = 0;
    wave(12, 6, 4);
    phase_end("after_reset");

    // Timeout: one rise then sig_in held low; flag rises 50 cycles later.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    armed = 0;
    repeat (2) @(negedge clk);
    bus.sig_in = 1'b1;
    for (int i = 1; i <= 53; i++) begin
      @(negedge clk);
      if (i == 4)  bus.sig_in = 1'b0;
      if (i == 52) check("timeout_before_50", 64'(bus.timeout), 64'd0);
      if (i == 53) check("timeout_at_50",     64'(bus.timeout), 64'd1);
    end
    wave(8, 3, 1);
    check("timeout_held_while_arming", 64'(bus.timeout), 64'd1);
    wave(8, 3, 3);
    check("timeout_cleared", 64'(bus.timeout), 64'd0);
    phase_end("timeout_resume");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
